// File: rtl/lock_access_controller.sv
// Keypad door lock sequencer: edge-detects keys, buffers a 4-digit entry, checks it, and times unlock/lockout.
// Latency: a switch sampled high at one edge is acted on (state and display) at the following edge.
// Backpressure: none; events that arrive in states that do not use them are dropped.
module lock_access_controller #(
  parameter logic [15:0] CODE_DEFAULT   = 16'h2601,
  parameter int          MAX_FAIL       = 3,
  parameter int          UNLOCK_CYCLES  = 50000000,
  parameter int          LOCKOUT_CYCLES = 500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] key,
  input  logic       enter,
  input  logic       clear,
  input  logic       prog,
  output logic       unlock,
  output logic       locked_out,
  output logic [3:0] fail_cnt,
  output logic [6:0] h1,
  output logic [6:0] h2,
  output logic [6:0] h3,
  output logic [6:0] h4
);

  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, PROGRAM, LOCKOUT} state_t;

  state_t          state, state_n;
  logic [15:0]     buffer, buffer_n, code, code_n;
  logic [2:0]      count, count_n;
  logic [3:0]      fail_n, fail_inc;
  logic [TW-1:0]   timer, timer_n;
  logic [3:0][6:0] disp, disp_n;
  logic [9:0]      key_q, key_qq, key_ev;
  logic            enter_q, enter_qq, clear_q, clear_qq, prog_q, prog_qq;
  logic            enter_ev, clear_ev, prog_ev, dig_vld;
  logic [3:0]      dig;
  logic [15:0]     appended;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b0000001;
      4'd1: seg7 = 7'b1001111;
      4'd2: seg7 = 7'b0010010;
      4'd3: seg7 = 7'b0000110;
      4'd4: seg7 = 7'b1001100;
      4'd5: seg7 = 7'b0100100;
      4'd6: seg7 = 7'b0100000;
      4'd7: seg7 = 7'b0001111;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0000100;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Two-stage input sampling; the second stage is the edge-detect reference.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= '0; key_qq <= '0;
      enter_q <= 1'b0; enter_qq <= 1'b0;
      clear_q <= 1'b0; clear_qq <= 1'b0;
      prog_q  <= 1'b0; prog_qq  <= 1'b0;
    end else begin
      key_q <= key;     key_qq <= key_q;
      enter_q <= enter; enter_qq <= enter_q;
      clear_q <= clear; clear_qq <= clear_q;
      prog_q  <= prog;  prog_qq  <= prog_q;
    end
  end

  // Rising-edge events; a digit counts only when exactly one key rose.
  always_comb begin
    key_ev   = key_q & ~key_qq;
    enter_ev = enter_q & ~enter_qq;
    clear_ev = clear_q & ~clear_qq;
    prog_ev  = prog_q & ~prog_qq;
    dig_vld  = (key_ev != 10'd0) && ((key_ev & (key_ev - 10'd1)) == 10'd0);
    dig      = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (key_ev[i]) dig = 4'(i);
    end
    appended = buffer | ({dig, 12'h000} >> {count, 2'b00});
    fail_inc = (fail_cnt == 4'(MAX_FAIL)) ? fail_cnt : fail_cnt + 4'd1;
  end

  // Next-state logic: clear beats enter beats digit.
  always_comb begin
    state_n  = state;
    buffer_n = buffer;
    count_n  = count;
    code_n   = code;
    fail_n   = fail_cnt;
    timer_n  = timer;
    case (state)
      IDLE: begin
        if (!clear_ev && !enter_ev && dig_vld) begin
          buffer_n = {dig, 12'h000};
          count_n  = 3'd1;
          state_n  = ENTRY;
        end
      end
      ENTRY: begin
        if (clear_ev) begin
          buffer_n = '0;
          count_n  = '0;
          state_n  = IDLE;
        end else if (enter_ev) begin
          state_n = CHECK;
        end else if (dig_vld && count < 3'd4) begin
          buffer_n = appended;
          count_n  = count + 3'd1;
        end
      end
      CHECK: begin
        buffer_n = '0;
        count_n  = '0;
        if (count == 3'd4 && buffer == code) begin
          fail_n  = '0;
          timer_n = TW'(UNLOCK_CYCLES - 1);
          state_n = OPEN;
        end else begin
          fail_n = fail_inc;
          if (fail_inc == 4'(MAX_FAIL)) begin
            timer_n = TW'(LOCKOUT_CYCLES - 1);
            state_n = LOCKOUT;
          end else begin
            state_n = IDLE;
          end
        end
      end
      OPEN: begin
        if (timer == '0) begin
          state_n = IDLE;
        end else begin
          timer_n = timer - 1'b1;
          if (prog_ev) state_n = PROGRAM;
        end
      end
      PROGRAM: begin
        if (clear_ev) begin
          buffer_n = '0;
          count_n  = '0;
        end else if (enter_ev) begin
          if (count == 3'd4) code_n = buffer;
          buffer_n = '0;
          count_n  = '0;
          state_n  = IDLE;
        end else if (dig_vld && count < 3'd4) begin
          buffer_n = appended;
          count_n  = count + 3'd1;
        end
      end
      LOCKOUT: begin
        if (timer == '0) begin
          fail_n  = '0;
          state_n = IDLE;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Display image for the state being entered; CHECK keeps whatever was shown.
  always_comb begin
    disp_n = disp;
    case (state_n)
      IDLE, ENTRY, PROGRAM: begin
        for (int i = 0; i < 4; i++) begin
          if (3'(i) < count_n) disp_n[i] = seg7(buffer_n[15 - 4*i -: 4]);
          else                 disp_n[i] = (state_n == PROGRAM) ? SEG_BLANK : SEG_DASH;
        end
      end
      OPEN:    disp_n = {7'b1101010, 7'b0110000, 7'b0011000, 7'b0000001};
      LOCKOUT: disp_n = {7'b1110001, 7'b1001111, 7'b0001000, 7'b0111000};
      default: disp_n = disp;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      buffer     <= '0;
      count      <= '0;
      code       <= CODE_DEFAULT;
      fail_cnt   <= '0;
      timer      <= '0;
      unlock     <= 1'b0;
      locked_out <= 1'b0;
      disp       <= {4{SEG_DASH}};
    end else begin
      state      <= state_n;
      buffer     <= buffer_n;
      count      <= count_n;
      code       <= code_n;
      fail_cnt   <= fail_n;
      timer      <= timer_n;
      unlock     <= (state_n == OPEN);
      locked_out <= (state_n == LOCKOUT);
      disp       <= disp_n;
    end
  end

  assign h1 = disp[0];
  assign h2 = disp[1];
  assign h3 = disp[2];
  assign h4 = disp[3];

endmodule

// File: tb/tb_lock_access_controller.sv
// Bench for lock_access_controller: transaction-level model feeds expectation queues;
// independent monitors compare display snapshots and every unlock/lockout pulse.
module tb_lock_access_controller;

  localparam int U    = 8;
  localparam int L    = 16;
  localparam int MAXF = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] key = '0;
  logic       enter = 1'b0, clear = 1'b0, prog = 1'b0;
  logic       unlock, locked_out;
  logic [3:0] fail_cnt;
  logic [6:0] h1, h2, h3, h4;

  lock_access_controller #(
    .CODE_DEFAULT(16'h2601), .MAX_FAIL(MAXF), .UNLOCK_CYCLES(U), .LOCKOUT_CYCLES(L)
  ) dut (
    .clk(clk), .rst(rst), .key(key), .enter(enter), .clear(clear), .prog(prog),
    .unlock(unlock), .locked_out(locked_out), .fail_cnt(fail_cnt),
    .h1(h1), .h2(h2), .h3(h3), .h4(h4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (per-transaction) ----------------
  typedef enum {M_IDLE, M_ENTRY, M_OPEN, M_PROG, M_LOCK} mode_t;
  typedef struct { int width; bit trunc; logic [3:0] fcnt; } pulse_t;

  mode_t       m_mode;
  int          m_digits[$];
  logic [15:0] m_code;
  int          m_fails;
  pulse_t      uq[$];
  pulse_t      lq[$];
  logic [33:0] sq[$];
  logic        snap_req = 1'b0;

  function automatic logic [6:0] segof(input int d);
    case (d)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
      9: return 7'b0000100;  default: return 7'b1111111;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_digits.delete(); m_code = 16'h2601; m_fails = 0;
  endtask

  task automatic model_digit(input int d);
    if (m_mode == M_IDLE) begin
      m_digits.delete(); m_digits.push_back(d); m_mode = M_ENTRY;
    end else if ((m_mode == M_ENTRY || m_mode == M_PROG) && m_digits.size() < 4) begin
      m_digits.push_back(d);
    end
  endtask

  task automatic model_clear();
    if (m_mode == M_ENTRY) begin m_digits.delete(); m_mode = M_IDLE; end
    else if (m_mode == M_PROG) m_digits.delete();
  endtask

  function automatic logic [15:0] digits_value();
    logic [15:0] v = '0;
    foreach (m_digits[i]) v = (v << 4) | 16'(m_digits[i]);
    return v;
  endfunction

  task automatic model_enter(input bit trunc);
    if (m_mode == M_ENTRY) begin
      if (m_digits.size() == 4 && digits_value() == m_code) begin
        m_fails = 0; m_mode = M_OPEN;
        uq.push_back('{U, trunc, 4'd0});
      end else begin
        if (m_fails < MAXF) m_fails++;
        if (m_fails == MAXF) begin
          m_mode = M_LOCK; lq.push_back('{L, 1'b0, 4'(MAXF)});
        end else m_mode = M_IDLE;
      end
      m_digits.delete();
    end else if (m_mode == M_PROG) begin
      if (m_digits.size() == 4) m_code = digits_value();
      m_digits.delete(); m_mode = M_IDLE;
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic pulse_in(input logic [9:0] k, input bit e, input bit c, input bit p);
    @(posedge clk); #1 key = k; enter = e; clear = c; prog = p;
    @(posedge clk); #1 key = '0; enter = 1'b0; clear = 1'b0; prog = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_digit(input int d);
    pulse_in(10'd1 << d, 0, 0, 0); model_digit(d); gap(2);
  endtask

  task automatic do_enter(input bit trunc);
    pulse_in('0, 1, 0, 0); model_enter(trunc); gap(2);
  endtask

  task automatic do_clear();
    pulse_in('0, 0, 1, 0); model_clear(); gap(2);
  endtask

  task automatic do_prog();
    pulse_in('0, 0, 0, 1); if (m_mode == M_OPEN) m_mode = M_PROG; gap(2);
  endtask

  task automatic do_mask(input logic [9:0] m);
    pulse_in(m, 0, 0, 0);
    for (int i = 0; i < 10; i++) if (m == (10'd1 << i)) model_digit(i);
    gap(2);
  endtask

  task automatic do_clear_enter();
    pulse_in('0, 1, 1, 0); model_clear(); gap(2);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset(); gap(2);
  endtask

  task automatic wait_expire();
    gap(L + 8);
    if (m_mode == M_OPEN) m_mode = M_IDLE;
    else if (m_mode == M_LOCK) begin m_fails = 0; m_mode = M_IDLE; end
  endtask

  task automatic type_code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) do_digit(int'((c >> (4*i)) & 16'hF));
  endtask

  task automatic snap();
    logic [27:0] hexp;
    for (int i = 0; i < 4; i++)
      hexp[27 - 7*i -: 7] = (i < m_digits.size()) ? segof(m_digits[i]) :
                            ((m_mode == M_PROG) ? 7'b1111111 : 7'b1111110);
    sq.push_back({4'(m_fails), 1'b0, 1'b0, hexp});
    @(posedge clk); #1 snap_req = 1'b1;
    @(posedge clk); #1 snap_req = 1'b0;
  endtask

  // ---------------- monitors ----------------
  initial forever begin
    @(negedge clk);
    if (snap_req) begin
      if (sq.size() == 0) check("snapshot_queue_empty", 1, 0);
      else check("snapshot", {fail_cnt, unlock, locked_out, h1, h2, h3, h4}, sq.pop_front());
    end
  end

  initial begin
    int w, bad; logic [3:0] f; bit act; pulse_t r;
    act = 0; w = 0; bad = 0; f = '0;
    forever begin
      @(negedge clk);
      if (unlock) begin
        if (!act) begin act = 1; w = 0; bad = 0; f = fail_cnt; end
        w++;
        if ({h1, h2, h3, h4} !== {7'b0000001, 7'b0011000, 7'b0110000, 7'b1101010}) bad++;
        if (w > 1000) begin check("unlock_stuck", w, U); act = 0; end
      end else if (act) begin
        act = 0;
        if (uq.size() == 0) check("unexpected_unlock_pulse", w, 0);
        else begin
          r = uq.pop_front();
          if (r.trunc) check("unlock_truncated_width", (w > 0 && w < U), 1);
          else         check("unlock_width", w, r.width);
          check("unlock_fail_cnt", f, r.fcnt);
          check("open_display_bad_cycles", bad, 0);
        end
      end
    end
  end

  initial begin
    int w, bad; logic [3:0] f; bit act; pulse_t r;
    act = 0; w = 0; bad = 0; f = '0;
    forever begin
      @(negedge clk);
      if (locked_out) begin
        if (!act) begin act = 1; w = 0; bad = 0; f = fail_cnt; end
        w++;
        if ({h1, h2, h3, h4} !== {7'b0111000, 7'b0001000, 7'b1001111, 7'b1110001} || unlock) bad++;
        if (w > 1000) begin check("lockout_stuck", w, L); act = 0; end
      end else if (act) begin
        act = 0;
        if (lq.size() == 0) check("unexpected_lockout", w, 0);
        else begin
          r = lq.pop_front();
          check("lockout_width", w, r.width);
          check("lockout_fail_cnt", f, r.fcnt);
          check("fail_display_bad_cycles", bad, 0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int op;
    model_reset();
    gap(3); #1 rst = 1'b0;
    gap(2);
    snap();                                         // reset state "----"

    type_code(16'h2601); snap();                    // shows 2 6 0 1
    do_enter(0); wait_expire(); snap();

    do_digit(2); do_digit(6); do_digit(0); do_enter(0); snap();   // short entry fails

    type_code(16'h2601); do_enter(0); wait_expire();
    for (int k = 0; k < 3; k++) begin type_code(16'h1111); do_enter(0); end
    do_digit(5); do_digit(2); do_enter(0);          // ignored during lockout
    wait_expire(); snap();

    type_code(16'h2601); do_enter(1); do_prog();    // program a new code
    do_digit(9); do_digit(8); do_digit(7); snap();
    do_digit(6); do_enter(0); snap();
    type_code(16'h2601); do_enter(0); snap();       // old code now fails
    type_code(16'h9876); do_enter(0); wait_expire(); snap();
    do_reset(); snap();
    type_code(16'h2601); do_enter(0); wait_expire(); snap();

    do_mask(10'b0000000101); snap();                // two keys together rejected
    do_digit(2); do_mask(10'b0000110000); snap();
    do_digit(6); do_digit(0); do_digit(1); do_clear_enter(); snap();

    type_code(16'h2601); do_digit(5); snap();       // fifth digit dropped
    do_enter(0); wait_expire(); snap();

    type_code(16'h2601); do_enter(1); gap(1); do_reset(); snap();  // reset during OPEN

    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 5)      do_digit($urandom_range(0, 9));
      else if (op == 6) do_enter(0);
      else if (op == 7) do_clear();
      else if (op == 8) begin type_code(16'h2601); do_enter(0); end
      else begin
        for (int i = 0; i < 4; i++) do_digit($urandom_range(0, 9));
        do_enter(0);
      end
      if (m_mode == M_OPEN || m_mode == M_LOCK) wait_expire();
      snap();
    end

    gap(30);
    check("unlock_pulses_outstanding", uq.size(), 0);
    check("lockouts_outstanding", lq.size(), 0);
    check("snapshots_outstanding", sq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
